gray_sync_dec: RTL and testbench
================================

Name: gray_sync_dec

Overview:
- Receive end of the Gray-coded counter path: samples a Gray count produced in another clock domain and synchronizes it into the local `clk` domain.
- Converts the synchronized value to binary in a registered stage.
- Reports the binary value, the per-update increment (delta), and single-step violations.
- Used as the read side of pointer and frame-position crossings, paired with the gcnt Gray counter.

Parameters:
- WIDTH, 8, width of the Gray input and of all binary outputs.
- SYNC_STAGES, 2, number of synchronizer flops; legal range 2..4.

Ports:
- clk  in  1  local clock.
- aclr  in  1  asynchronous active-high reset.
- ena  in  1  update enable for the conversion and output stage.
- gray_in  in  WIDTH  Gray count from the foreign domain.
- err_clr  in  1  clears err_sticky.
- bin_out  out  WIDTH  synchronized binary count.
- bin_valid  out  1  pipeline primed since reset.
- delta  out  WIDTH  bin_out minus previous bin_out, modulo 2^WIDTH.
- step_err  out  1  one-cycle pulse: more than one Gray bit changed between consecutive enabled samples.
- err_sticky  out  1  latched step_err.

Behaviour:
- One clock, `clk`. Reset `aclr` is asynchronous and active-high. All flops, including the synchronizer chain, are reset by `aclr`.
- Reset values: sync chain 0, gray_s 0, gray_prev 0, bin_out 0, delta 0, bin_valid 0, step_err 0, err_sticky 0.
- Gray 0 decodes to binary 0, which matches the gcnt reset value.
- Sync chain:
  - Free-running every `clk`, regardless of `ena`.
  - Its output is gray_s, taken from the last stage.
- Conversion stage, on a cycle with ena=1:
  - bin_out <= gray2bin(gray_s).
  - delta <= gray2bin(gray_s) - bin_out, truncated to WIDTH.
  - gray_prev <= gray_s.
  - step_err <= (popcount(gray_s ^ gray_prev) > 1), qualified as described under the step check.
- Conversion stage, on a cycle with ena=0:
  - bin_out and gray_prev hold.
  - delta <= 0 and step_err <= 0.
- Latency: a gray_in change stable before clk edge N appears on bin_out after edge N+SYNC_STAGES. That is SYNC_STAGES+1 edges including the input sample, which is 3 for the default.
- bin_valid:
  - Counts SYNC_STAGES+1 enabled cycles after aclr deassertion, then rises.
  - Stays high until the next aclr.
  - While bin_valid=0, step_err is forced to 0 and delta is forced to 0.
- Step check, suppressed on:
  - the first enabled cycle after any ena=0 cycle, because a gap legitimately spans multiple steps;
  - any cycle where bin_valid=0.
- Wrap-around: delta is modulo arithmetic. Gray 8'h80 (bin 255) followed by 8'h00 gives bin_out 0 and delta 1.
- Zero change: a repeated sample gives delta 0 and step_err 0.
- err_sticky: set when step_err=1; cleared when err_clr=1. Set wins if both occur in the same cycle.
- Reset mid-operation: all outputs go to their reset values immediately on aclr, with no clock required. bin_valid restarts its count on release.
- Usage constraint: the source increment rate must be at most one step per two local `clk` cycles. Above that rate, step_err is diagnostic only and bin_out remains a valid monotonic sample.
- Decoding: gray2bin is a prefix XOR from the MSB down, b[i] = ^g[WIDTH-1:i], fully combinational before the bin_out register.

Decomposition:
- Package gray_pkg holds:
  - function gray2bin (parameterized by WIDTH via a `$bits`-agnostic loop);
  - function bin2gray, for bench use;
  - function popcount;
  - localparam SYNC_MIN = 2.
- Sub-module sync_ff:
  - SYNC_STAGES-deep, WIDTH-wide synchronizer with async aclr;
  - reused for other crossings.
- The top module holds conversion, delta, the step check, and the valid/error logic.

Test Plan (WIDTH=8, SYNC_STAGES=2, ena=1 unless noted):
- Reset: pulse aclr with gray_in=0 -> all outputs 0; bin_valid rises on the 3rd clk edge after release.
- Sweep: drive bin2gray(0..255) then 0, one value per 4 clk -> bin_out follows 0..255,0 with 3-edge latency; delta=1 on each update and 0 otherwise; step_err never asserts.
- Wrap: gray_in 8'h80 -> 8'h00 -> bin_out 255 -> 0, delta=1, step_err=0.
- Violation: gray_in 8'h00 -> 8'h03 -> bin_out=2, delta=2, step_err one-cycle pulse, err_sticky=1 until err_clr. Repeating with err_clr asserted in the pulse cycle -> err_sticky stays 1.
- Enable gap: bin_out=5 (gray 8'h07); ena=0 while gray_in steps to 8'h0D (bin 9); then ena=1 -> bin_out 9, delta=4, step_err=0.
- Mid-run reset: aclr asserted asynchronously while bin_out=8'h55 and err_sticky=1 -> bin_out, delta, err_sticky, bin_valid all 0 before the next clk edge; normal operation resumes after release.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the counter crossing path.
// Functions take a fixed wide argument; callers zero-extend, which a prefix XOR tolerates.
package gray_pkg;

  localparam int SYNC_MIN = 2;
  localparam int GMAX_W   = 64;

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic logic [GMAX_W-1:0] gray2bin(input logic [GMAX_W-1:0] g);
    logic [GMAX_W-1:0] b;
    logic              acc;
    b   = '0;
    acc = 1'b0;
    for (int i = GMAX_W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [GMAX_W-1:0] bin2gray(input logic [GMAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [GMAX_W-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < GMAX_W; i++) begin
      cnt = cnt + 32'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage, multi-bit synchronizer with asynchronous clear.
// Only suitable for buses where at most one bit changes per source update (e.g. Gray codes).
module sync_ff #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [STAGES];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      stage_reg[0] <= '0;
    end else begin
      stage_reg[0] <= d;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi < STAGES; gi++) begin : g_stage
      always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
          stage_reg[gi] <= '0;
        end else begin
          stage_reg[gi] <= stage_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/gray_sync_dec.sv
// Receive side of a Gray counter crossing: synchronize, decode to binary,
// and report per-update delta plus multi-bit-step violations.
module gray_sync_dec
  import gray_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             ena,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic             err_sticky
);

  localparam int STAGES = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam int CNT_W  = $clog2(STAGES + 1);

  logic [WIDTH-1:0] gray_s;
  logic [WIDTH-1:0] gray_prev_reg;
  logic [WIDTH-1:0] bin_next;
  logic [CNT_W-1:0] prime_cnt_reg;
  logic             ena_prev_reg;
  logic             step_next;

  sync_ff #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES)
  ) u_sync (
    .clk  (clk),
    .aclr (aclr),
    .d    (gray_in),
    .q    (gray_s)
  );

  // A sample right after an ena gap may legitimately jump several steps.
  always_comb begin
    bin_next  = WIDTH'(gray2bin(GMAX_W'(gray_s)));
    step_next = bin_valid && ena_prev_reg &&
                (popcount(GMAX_W'(gray_s ^ gray_prev_reg)) > 1);
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      gray_prev_reg <= '0;
      prime_cnt_reg <= '0;
      ena_prev_reg  <= 1'b0;
      bin_out       <= '0;
      bin_valid     <= 1'b0;
      delta         <= '0;
      step_err      <= 1'b0;
      err_sticky    <= 1'b0;
    end else begin
      ena_prev_reg <= ena;
      err_sticky   <= step_err | (err_sticky & ~err_clr);
      if (ena) begin
        bin_out       <= bin_next;
        gray_prev_reg <= gray_s;
        delta         <= bin_valid ? (bin_next - bin_out) : '0;
        step_err      <= step_next;
        if (!bin_valid) begin
          if (prime_cnt_reg == CNT_W'(STAGES)) begin
            bin_valid <= 1'b1;
          end else begin
            prime_cnt_reg <= prime_cnt_reg + 1'b1;
          end
        end
      end else begin
        delta    <= '0;
        step_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_sync_dec.sv
// Self-checking bench for gray_sync_dec: vector table, directed corner sequences,
// and randomized traffic against a behavioural model.
module tb_gray_sync_dec;
  import gray_pkg::*;

  localparam int W  = 8;
  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         aclr = 1'b1;
  logic         ena = 1'b1;
  logic         err_clr = 1'b0;
  logic [W-1:0] gray_in = '0;
  logic [W-1:0] bin_out;
  logic         bin_valid;
  logic [W-1:0] delta;
  logic         step_err;
  logic         err_sticky;

  int total = 0;
  int bad   = 0;

  gray_sync_dec #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .aclr       (aclr),
    .ena        (ena),
    .gray_in    (gray_in),
    .err_clr    (err_clr),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .delta      (delta),
    .step_err   (step_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  // Behavioural model: the sync chain is a delay line of input samples.
  logic [W-1:0] m_pipe [SS];
  logic [W-1:0] m_bin, m_delta, m_gprev, m_gs;
  logic         m_step, m_sticky, m_valid, m_ena_prev;
  int           m_en_count;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [W-1:0] g_of(input logic [W-1:0] b);
    return W'(bin2gray(GMAX_W'(b)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SS; i++) m_pipe[i] = '0;
    m_bin = '0; m_delta = '0; m_gprev = '0; m_gs = '0;
    m_step = 1'b0; m_sticky = 1'b0; m_valid = 1'b0; m_ena_prev = 1'b0;
    m_en_count = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    m_gs = m_pipe[SS-1];
    for (int i = SS - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = gray_in;
    m_sticky = m_step | (m_sticky & !err_clr);
    if (ena) begin
      m_delta = m_valid ? W'(ref_g2b(m_gs) - m_bin) : '0;
      m_step  = m_valid && m_ena_prev && ($countones(m_gs ^ m_gprev) > 1);
      m_bin   = ref_g2b(m_gs);
      m_gprev = m_gs;
      m_en_count++;
      if (m_en_count >= SS + 1) m_valid = 1'b1;
    end else begin
      m_delta = '0;
      m_step  = 1'b0;
    end
    m_ena_prev = ena;
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".bin"},    int'(bin_out),    int'(m_bin));
    chk({tag, ".delta"},  int'(delta),      int'(m_delta));
    chk({tag, ".step"},   int'(step_err),   int'(m_step));
    chk({tag, ".sticky"}, int'(err_sticky), int'(m_sticky));
    chk({tag, ".valid"},  int'(bin_valid),  int'(m_valid));
  endtask

  task automatic cycle(input logic e, input logic [W-1:0] g, input logic c, input string tag);
    ena = e; gray_in = g; err_clr = c;
    model_step();
    @(negedge clk);
    check_all(tag);
  endtask

  typedef struct {
    logic         ena;
    logic [W-1:0] g;
    logic [W-1:0] bin;
    logic [W-1:0] dlt;
    logic         valid;
  } vec_t;

  vec_t tbl [8];
  int   step_seen;
  logic [W-1:0] cnt_b;

  initial begin
    // Rows: inputs for the next edge, then expected outputs after it.
    tbl[0] = '{1'b1, 8'h00, 8'd0, 8'd0, 1'b0};
    tbl[1] = '{1'b1, 8'h00, 8'd0, 8'd0, 1'b0};
    tbl[2] = '{1'b1, 8'h01, 8'd0, 8'd0, 1'b1};
    tbl[3] = '{1'b1, 8'h01, 8'd0, 8'd0, 1'b1};
    tbl[4] = '{1'b1, 8'h01, 8'd1, 8'd1, 1'b1};
    tbl[5] = '{1'b1, 8'h03, 8'd1, 8'd0, 1'b1};
    tbl[6] = '{1'b1, 8'h03, 8'd1, 8'd0, 1'b1};
    tbl[7] = '{1'b1, 8'h03, 8'd2, 8'd1, 1'b1};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.bin",    int'(bin_out),    0);
    chk("reset.delta",  int'(delta),      0);
    chk("reset.step",   int'(step_err),   0);
    chk("reset.sticky", int'(err_sticky), 0);
    chk("reset.valid",  int'(bin_valid),  0);
    aclr = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ena = tbl[i].ena; gray_in = tbl[i].g; err_clr = 1'b0;
      model_step();
      @(negedge clk);
      chk($sformatf("tbl%0d.bin", i),   int'(bin_out),   int'(tbl[i].bin));
      chk($sformatf("tbl%0d.delta", i), int'(delta),     int'(tbl[i].dlt));
      chk($sformatf("tbl%0d.valid", i), int'(bin_valid), int'(tbl[i].valid));
      chk($sformatf("tbl%0d.step", i),  int'(step_err),  0);
    end

    // Sweep 0..255 then 0, four clocks per value.
    step_seen = 0;
    for (int v = 0; v <= 256; v++) begin
      for (int k = 0; k < 4; k++) begin
        cycle(1'b1, g_of(W'(v)), 1'b0, "sweep");
        if (v > 0 && step_err) step_seen++;
        if (v > 0 && k == 1) chk("sweep.latency_hold", int'(bin_out), (v - 1) & 8'hFF);
        if (v > 0 && k == 2) begin
          chk("sweep.latency_bin", int'(bin_out), v & 8'hFF);
          chk("sweep.delta1",      int'(delta),   1);
        end
      end
    end
    chk("sweep.no_step", step_seen, 0);

    // Enable gap: 5 -> (ena off while source reaches 9) -> 9 with delta 4.
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'h07, 1'b1, "gap_pre");
    chk("gap.bin5", int'(bin_out), 5);
    for (int k = 0; k < 4; k++) cycle(1'b0, 8'h0D, 1'b0, "gap_off");
    chk("gap.hold_bin", int'(bin_out), 5);
    chk("gap.hold_delta", int'(delta), 0);
    cycle(1'b1, 8'h0D, 1'b0, "gap_on");
    chk("gap.bin9", int'(bin_out), 9);
    chk("gap.delta4", int'(delta), 4);
    chk("gap.no_step", int'(step_err), 0);

    // Wrap: bin 255 -> 0.
    for (int k = 0; k < 4; k++) cycle(1'b1, 8'h80, 1'b0, "wrap_pre");
    chk("wrap.bin255", int'(bin_out), 255);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h00, 1'b0, "wrap");
    chk("wrap.bin0", int'(bin_out), 0);
    chk("wrap.delta1", int'(delta), 1);
    chk("wrap.no_step", int'(step_err), 0);

    // Violation 00 -> 03, then 03 -> 00 with err_clr in the pulse cycle.
    for (int k = 0; k < 2; k++) cycle(1'b1, 8'h00, 1'b1, "viol_clr");
    chk("viol.sticky_clear", int'(err_sticky), 0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h03, 1'b0, "viol1");
    chk("viol1.bin2", int'(bin_out), 2);
    chk("viol1.delta2", int'(delta), 2);
    chk("viol1.pulse", int'(step_err), 1);
    cycle(1'b1, 8'h03, 1'b0, "viol1_after");
    chk("viol1.pulse_end", int'(step_err), 0);
    chk("viol1.sticky_set", int'(err_sticky), 1);
    cycle(1'b1, 8'h03, 1'b0, "viol1_hold");
    chk("viol1.sticky_hold", int'(err_sticky), 1);
    cycle(1'b1, 8'h03, 1'b1, "viol1_clr");
    chk("viol1.sticky_clr", int'(err_sticky), 0);
    for (int k = 0; k < 3; k++) cycle(1'b1, 8'h00, 1'b0, "viol2");
    chk("viol2.pulse", int'(step_err), 1);
    cycle(1'b1, 8'h00, 1'b1, "viol2_setwins");
    chk("viol2.set_wins", int'(err_sticky), 1);
    cycle(1'b1, 8'h00, 1'b1, "viol2_clr");
    chk("viol2.sticky_clr", int'(err_sticky), 0);

    // Mid-run asynchronous reset with bin 0x55 and sticky error set.
    for (int k = 0; k < 4; k++) cycle(1'b1, g_of(8'h55), 1'b0, "mid_pre");
    chk("mid.bin55", int'(bin_out), 8'h55);
    chk("mid.sticky1", int'(err_sticky), 1);
    #2 aclr = 1'b1;
    #1;
    chk("mid.async_bin",    int'(bin_out),    0);
    chk("mid.async_delta",  int'(delta),      0);
    chk("mid.async_sticky", int'(err_sticky), 0);
    chk("mid.async_valid",  int'(bin_valid),  0);
    model_reset();
    @(negedge clk);
    aclr = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b1, g_of(8'h55), 1'b0, "mid_prime");
    chk("mid.valid_again", int'(bin_valid), 1);

    // Randomized traffic: mostly slow single steps, occasional jumps and gaps.
    cnt_b = 8'h55;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 3) cnt_b = W'($urandom);
      else if (n % 3 == 0) cnt_b = cnt_b + 1'b1;
      cycle(logic'($urandom_range(0, 9) != 0), g_of(cnt_b),
            logic'($urandom_range(0, 9) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
